instr_fetch_unit: RTL and testbench

- Single-issue instruction fetch sequencer: the producer end of the control-unit interface.
- Fetches 32-bit RV32 words from instruction memory over a valid/ready request plus valid response port.
- Presents opcode/funct3/funct7 and the word to the decode/control stage.
- Consumes pc_source_code back from the control unit to select the next PC.

---
 rtl/rv_fetch_pkg.sv | 30 +++
 rtl/instr_fetch_unit_pc_next_sel.sv | 38 +++
 rtl/instr_fetch_unit.sv | 98 +++++++++
 tb/tb_instr_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared fetch-side definitions: FSM state codes, pc_source_code encodings
// agreed with the control unit, and RV32 base opcodes.
package rv_fetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_BOOT = 2'd0;
    localparam fetch_state_t ST_REQ  = 2'd1;
    localparam fetch_state_t ST_WAIT = 2'd2;
    localparam fetch_state_t ST_HOLD = 2'd3;

    localparam logic [1:0] PC_SRC_SEQ     = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH  = 2'b01;
    localparam logic [1:0] PC_SRC_JAL     = 2'b10;
    localparam logic [1:0] PC_SRC_ILLEGAL = 2'b11;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Combinational next-pc mux: picks the successor address from the control
// unit's pc_source_code and flags illegal codes and misaligned targets.
module pc_next_sel
    import rv_fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pc_source_code,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jal_target,
    output logic [XLEN-1:0] next_pc,
    output logic            set_fetch_err,
    output logic            set_misalign_err
);

    logic [XLEN-1:0] raw_pc;

    always_comb begin
        raw_pc        = pc + XLEN'(4);
        set_fetch_err = 1'b0;
        case (pc_source_code)
            PC_SRC_SEQ:     raw_pc = pc + XLEN'(4);
            PC_SRC_BRANCH:  raw_pc = branch_target;
            PC_SRC_JAL:     raw_pc = jal_target;
            PC_SRC_ILLEGAL: begin
                raw_pc        = pc + XLEN'(4);
                set_fetch_err = 1'b1;
            end
            default:        raw_pc = pc + XLEN'(4);
        endcase
    end

    // A misaligned target still redirects fetch, just to the enclosing word.
    assign set_misalign_err = |raw_pc[1:0];
    assign next_pc          = {raw_pc[XLEN-1:2], 2'b00};

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-issue RV32 fetch sequencer: one outstanding imem request, holds the
// fetched word for the control unit until accepted, then redirects the pc.
module instr_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic            funct7,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic [1:0]      pc_source_code,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jal_target,
    output logic [31:0]     instr_count,
    output logic            fetch_err,
    output logic            misalign_err
);

    // state   | meaning
    // BOOT    | one idle cycle after reset before the first request
    // REQ     | request pc from imem, waiting for imem_req_ready
    // WAIT    | request accepted, waiting for imem_rsp_valid
    // HOLD    | instruction presented, waiting for instr_ready

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic            accept;
    logic [XLEN-1:0] next_pc;
    logic            set_fetch_err;
    logic            set_misalign_err;

    assign accept = (state == ST_HOLD) && instr_ready;

    pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
        .pc               (pc),
        .pc_source_code   (pc_source_code),
        .branch_target    (branch_target),
        .jal_target       (jal_target),
        .next_pc          (next_pc),
        .set_fetch_err    (set_fetch_err),
        .set_misalign_err (set_misalign_err)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT: state_next = ST_REQ;
            ST_REQ:  if (imem_req_ready) state_next = ST_WAIT;
            ST_WAIT: if (imem_rsp_valid) state_next = ST_HOLD;
            ST_HOLD: if (instr_ready)    state_next = ST_REQ;
            default: state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_BOOT;
            pc           <= RESET_PC;
            instr        <= NOP_INSTR;
            instr_count  <= 32'd0;
            fetch_err    <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_WAIT && imem_rsp_valid) begin
                instr <= imem_rsp_data;
            end
            if (accept) begin
                pc           <= next_pc;
                instr_count  <= instr_count + 32'd1;
                fetch_err    <= fetch_err | set_fetch_err;
                misalign_err <= misalign_err | set_misalign_err;
            end
        end
    end

    assign imem_req_valid = (state == ST_REQ);
    assign imem_addr      = pc;
    assign instr_valid    = (state == ST_HOLD);
    assign opcode         = instr[6:0];
    assign funct3         = instr[14:12];
    assign funct7         = instr[30];
    assign pc_plus4       = pc + XLEN'(4);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed boot/redirect/error/reset
// scenarios followed by randomized fetches against an address-level model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  pc_source_code;
    logic [31:0] branch_target;
    logic [31:0] jal_target;
    logic [31:0] instr_count;
    logic        fetch_err;
    logic        misalign_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_count;
    logic        exp_ferr;
    logic        exp_merr;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .pc_source_code (pc_source_code),
        .branch_target  (branch_target),
        .jal_target     (jal_target),
        .instr_count    (instr_count),
        .fetch_err      (fetch_err),
        .misalign_err   (misalign_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc    = 32'h0;
        exp_count = 32'h0;
        exp_ferr  = 1'b0;
        exp_merr  = 1'b0;
    endtask

    // Reference successor: the control unit's choice, then word-aligned.
    task automatic model_accept(input logic [1:0] code, input logic [31:0] bt, input logic [31:0] jt);
        logic [31:0] target;
        exp_count = exp_count + 1;
        if (code == 2'd1)      target = bt;
        else if (code == 2'd2) target = jt;
        else                   target = exp_pc + 32'd4;
        if (code == 2'd3) exp_ferr = 1'b1;
        if (target % 4 != 0) begin
            exp_merr = 1'b1;
            target   = target - (target % 4);
        end
        exp_pc = target;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && !imem_req_valid; i++) step();
        check("req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("req_addr", imem_addr, exp_pc);
    endtask

    task automatic fetch(input logic [31:0] word, input int rq_d, input int rsp_d, input int hold_d,
                         input logic [1:0] code, input logic [31:0] bt, input logic [31:0] jt);
        wait_req();
        for (int i = 0; i < rq_d; i++) begin
            step();
            check("req_addr_stable", imem_addr, exp_pc);
            check("req_valid_hold", {31'b0, imem_req_valid}, 32'd1);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("wait_no_req", {31'b0, imem_req_valid}, 32'd0);
        check("wait_no_valid", {31'b0, instr_valid}, 32'd0);
        for (int i = 0; i < rsp_d; i++) begin
            step();
            check("wait_no_valid", {31'b0, instr_valid}, 32'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        for (int i = 0; i <= hold_d; i++) begin
            check("instr_valid", {31'b0, instr_valid}, 32'd1);
            check("instr", instr, word);
            check("opcode", {25'b0, opcode}, {25'b0, word[6:0]});
            check("funct3", {29'b0, funct3}, {29'b0, word[14:12]});
            check("funct7", {31'b0, funct7}, {31'b0, word[30]});
            check("pc", pc, exp_pc);
            check("pc_plus4", pc_plus4, exp_pc + 32'd4);
            check("count_hold", instr_count, exp_count);
            if (i < hold_d) step();
        end
        pc_source_code = code;
        branch_target  = bt;
        jal_target     = jt;
        instr_ready    = 1'b1;
        step();
        instr_ready    = 1'b0;
        pc_source_code = 2'($urandom);
        branch_target  = $urandom;
        jal_target     = $urandom;
        model_accept(code, bt, jt);
        check("count_after", instr_count, exp_count);
        check("fetch_err", {31'b0, fetch_err}, {31'b0, exp_ferr});
        check("misalign_err", {31'b0, misalign_err}, {31'b0, exp_merr});
        check("next_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("next_addr", imem_addr, exp_pc);
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b0;
        pc_source_code = 2'b00;
        branch_target  = 32'h0;
        jal_target     = 32'h0;
        model_reset();

        repeat (3) step();
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_count", instr_count, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_errs", {30'b0, fetch_err, misalign_err}, 32'd0);
        rst_n = 1'b1;
        check("boot_no_req", {31'b0, imem_req_valid}, 32'd0);
        step();
        check("boot_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("boot_addr", imem_addr, 32'h0);
        check("boot_instr_nop", instr, 32'h0000_0013);
        check("boot_no_instr_valid", {31'b0, instr_valid}, 32'd0);

        // Sequential, branch, then jal under backpressure.
        fetch(32'h0050_0093, 0, 0, 0, 2'b00, 32'h0, 32'h0);
        fetch(32'h0020_8133, 0, 0, 0, 2'b00, 32'h0, 32'h0);
        check("seq_count2", instr_count, 32'd2);
        fetch(32'h0000_0063, 0, 0, 0, 2'b01, 32'h40, 32'h0);
        fetch(32'h0C00_006F, 5, 0, 4, 2'b10, 32'h0, 32'h100);
        check("bp_count", instr_count, 32'd4);

        // Reset while waiting for the response at 0x100; stale rsp ignored.
        wait_req();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        check("mid_rst_instr", instr, 32'h0000_0013);
        check("mid_rst_req", {31'b0, imem_req_valid}, 32'd0);
        rst_n = 1'b1;
        check("mid_boot_no_valid", {31'b0, instr_valid}, 32'd0);
        step();
        check("mid_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("mid_addr", imem_addr, 32'h0);
        check("mid_instr_nop", instr, 32'h0000_0013);
        check("mid_count", instr_count, 32'd0);
        step();
        check("mid_stale_ignored", {31'b0, instr_valid}, 32'd0);
        check("mid_stale_instr", instr, 32'h0000_0013);
        imem_rsp_valid = 1'b0;
        model_reset();

        // Error flags: illegal code, then misaligned branch; both sticky.
        fetch(32'h0000_0063, 0, 0, 0, 2'b01, 32'h10, 32'h0);
        fetch(32'h0000_0013, 0, 1, 0, 2'b11, 32'h0, 32'h0);
        check("illegal_addr", imem_addr, 32'h14);
        fetch(32'h0000_0063, 0, 0, 0, 2'b01, 32'h22, 32'h0);
        check("misalign_addr", imem_addr, 32'h20);
        fetch(32'h0000_0013, 1, 0, 1, 2'b00, 32'h0, 32'h0);

        // pc + 4 wraps modulo 2^32.
        fetch(32'h0000_006F, 0, 0, 0, 2'b10, 32'h0, 32'hFFFF_FFFC);
        fetch(32'h0000_0013, 0, 0, 0, 2'b00, 32'h0, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);

        for (int n = 0; n < 25; n++) begin
            fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  2'($urandom_range(0, 3)), $urandom, $urandom);
        end

        rst_n = 1'b0;
        step();
        check("final_rst_errs", {30'b0, fetch_err, misalign_err}, 32'd0);
        check("final_rst_count", instr_count, 32'd0);
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
